// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad by driving one column low at a time and reading
//   the pulled-up rows. A detected key is debounced over DEBOUNCE_CNT slot
//   ticks and then reported through a valid/ack handshake. A key must also be
//   seen released for DEBOUNCE_CNT ticks before scanning resumes, so each press
//   is reported only once.
//
//   Optional feature macro: KEYPAD_ACCUM_EN
//     When defined, each reported key also feeds a saturating decimal
//     accumulator on num_out (digits append, C clears). When it is not
//     defined, num_out is tied to zero.
//
// Parameters
//   SCAN_DIV      clk cycles per column slot (>= 2)
//   DEBOUNCE_CNT  consecutive equal tick samples needed for a press or release
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active-low
//   row_in     in   4   keypad rows, 0 = pressed, asynchronous to clk
//   col_out    out  4   one-cold column drive, 0 = column active
//   key_code   out  4   code of the last accepted key
//   key_valid  out  1   high while key_code holds an unacknowledged key
//   key_ack    in   1   consumer acknowledge
//   overrun    out  1   sticky, a key arrived while key_valid was high
//   num_out    out  13  accumulated decimal value
module keypad_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        overrun,
  output logic [12:0] num_out
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  logic [3:0]        row_meta_r;
  logic [3:0]        row_sync_r;
  logic [SLOT_W-1:0] slot_cnt_r;
  logic              tick_s;
  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic [3:0]        col_r;
  logic [3:0]        col_s;
  logic [1:0]        lat_row_r;
  logic [1:0]        lat_row_s;
  logic              report_s;
  logic [3:0]        report_code_s;
  logic [3:0]        key_code_r;
  logic              key_valid_r;
  logic              overrun_r;

  // Lowest-index low row; only meaningful when at least one row is low.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (rows[0] == 1'b0) begin
      idx = 2'd0;
    end else if (rows[1] == 1'b0) begin
      idx = 2'd1;
    end else if (rows[2] == 1'b0) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Key code for the active (one-cold) column and a row index.
  function automatic logic [3:0] key_map(input logic [3:0] col, input logic [1:0] row);
    logic [3:0] code;
    case ({col, row})
      {4'b1110, 2'd0}: code = 4'h1;
      {4'b1110, 2'd1}: code = 4'h4;
      {4'b1110, 2'd2}: code = 4'h7;
      {4'b1110, 2'd3}: code = 4'h0;
      {4'b1101, 2'd0}: code = 4'h2;
      {4'b1101, 2'd1}: code = 4'h5;
      {4'b1101, 2'd2}: code = 4'h8;
      {4'b1101, 2'd3}: code = 4'hF;
      {4'b1011, 2'd0}: code = 4'h3;
      {4'b1011, 2'd1}: code = 4'h6;
      {4'b1011, 2'd2}: code = 4'h9;
      {4'b1011, 2'd3}: code = 4'hE;
      {4'b0111, 2'd0}: code = 4'hA;
      {4'b0111, 2'd1}: code = 4'hB;
      {4'b0111, 2'd2}: code = 4'hC;
      {4'b0111, 2'd3}: code = 4'hD;
      default:         code = 4'h0;
    endcase
    return code;
  endfunction

  // Next one-cold column: the zero moves up one position, column 3 wraps to 0.
  function automatic logic [3:0] next_col(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row_in;
      row_sync_r <= row_meta_r;
    end
  end

  // Slot counter; its last cycle is the sampling tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_r <= {SLOT_W{1'b0}};
    end else if (slot_cnt_r == SLOT_LAST) begin
      slot_cnt_r <= {SLOT_W{1'b0}};
    end else begin
      slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
    end
  end

  assign tick_s = (slot_cnt_r == SLOT_LAST);

  // FSM state, debounce counter, column drive and latched row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_SCAN;
      cnt_r     <= {CNT_W{1'b0}};
      col_r     <= 4'b1110;
      lat_row_r <= 2'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      col_r     <= col_s;
      lat_row_r <= lat_row_s;
    end
  end

  // Next-state logic. The column stays put while a key is being confirmed
  // or held, so col_r doubles as the latched column.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    col_s         = col_r;
    lat_row_s     = lat_row_r;
    report_s      = 1'b0;
    report_code_s = key_map(col_r, lat_row_r);
    case (state_r)
      ST_SCAN: begin
        if (!tick_s) begin
          state_s = ST_SCAN;
        end else if (row_sync_r == 4'hF) begin
          col_s = next_col(col_r);
        end else begin
          lat_row_s = low_row(row_sync_r);
          cnt_s     = CNT_W'(1);
          state_s   = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        if (!tick_s) begin
          state_s = ST_CONFIRM;
        end else if (row_sync_r[lat_row_r] == 1'b0) begin
          if ((cnt_r + CNT_W'(1)) >= CNT_DONE) begin
            report_s = 1'b1;
            state_s  = ST_HELD;
            cnt_s    = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          // Bounce: drop the candidate silently and move on.
          state_s = ST_SCAN;
          cnt_s   = {CNT_W{1'b0}};
          col_s   = next_col(col_r);
        end
      end
      ST_HELD: begin
        if (!tick_s) begin
          state_s = ST_HELD;
        end else if (row_sync_r[lat_row_r] == 1'b1) begin
          if ((cnt_r + CNT_W'(1)) >= CNT_DONE) begin
            state_s = ST_SCAN;
            cnt_s   = {CNT_W{1'b0}};
            col_s   = next_col(col_r);
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          // Release must be seen on consecutive ticks.
          cnt_s = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_s   = ST_SCAN;
        cnt_s     = {CNT_W{1'b0}};
        col_s     = 4'b1110;
        lat_row_s = 2'd0;
      end
    endcase
  end

  // Report handshake: load on report, flag overrun if the consumer is late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (report_s) begin
      if (!key_valid_r || key_ack) begin
        key_code_r  <= report_code_s;
        key_valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (key_ack && key_valid_r) begin
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      key_valid_r <= key_valid_r;
    end
  end

  assign col_out   = col_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign overrun   = overrun_r;

`ifdef KEYPAD_ACCUM_EN
  logic [12:0] num_r;
  logic [16:0] prod_s;

  // Append the digit in 17 bits; the worst case 8191*10+9 still fits.
  always_comb begin
    prod_s = 17'(num_r) * 17'd10 + 17'(report_code_s);
  end

  // Decimal accumulator: digits append with saturation, C clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_r <= 13'd0;
    end else if (report_s) begin
      if (report_code_s <= 4'd9) begin
        if (prod_s > 17'd8191) begin
          num_r <= 13'd8191;
        end else begin
          num_r <= prod_s[12:0];
        end
      end else if (report_code_s == 4'hC) begin
        num_r <= 13'd0;
      end else begin
        num_r <= num_r;
      end
    end else begin
      num_r <= num_r;
    end
  end

  assign num_out = num_r;
`else
  assign num_out = 13'd0;
`endif

endmodule
